dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port (ram) between two requesters: port 0 is the cpu load/store
//  path and port 1 is a loader/debug master. Round-robin arbitration, one transaction at a time.
//  Sequences each access through a fixed-latency memory read pipe and returns the data to the winner.
//  Sits between cpu/loader and dmem in the top level and testbench.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports
//  RD_LAT  1   memory read latency in cycles, issue to mem_rdata valid; legal range >= 1
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  p0_req     in   1       port 0 request; held with fields stable until p0_ack
//  p0_we      in   1       port 0 write (1) / read (0)
//  p0_addr    in   ADDR_W  port 0 address
//  p0_wdata   in   DATA_W  port 0 write data
//  p0_ack     out  1       port 0 completion pulse, 1 cycle
//  p0_rdata   out  DATA_W  port 0 read data, valid while p0_ack=1 on a read
//  p1_*       -    -       identical set for port 1 (req, we, addr, wdata, ack, rdata)
//  mem_en     out  1       memory access strobe
//  mem_wen    out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid RD_LAT cycles after mem_en on a read
// BEHAVIOUR
//  Reset:
//   - state=IDLE; mem_en, mem_wen, p0_ack, p1_ack = 0; mem_addr, mem_wdata, p*_rdata = 0.
//   - Priority pointer set so port 0 wins the first contended arbitration.
//   - Reset mid-transaction drops the access: no ack is issued and captured read data is discarded.
//  FSM states: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> RESP -> IDLE.
//  IDLE:
//   - If any req is high, latch winner id, we, addr, wdata; go to ISSUE.
//   - Single requester wins outright.
//   - Both high: the port not granted last wins. Pointer updates on every grant.
//  ISSUE (1 cycle):
//   - mem_en=1, mem_addr/mem_wdata/mem_wen from the latched fields.
//   - Write: winner's ack=1 this cycle; return to IDLE.
//   - Read: load counter with RD_LAT-1; go to WAIT.
//  WAIT (RD_LAT cycles):
//   - Counter decrements each cycle.
//   - When it reaches 0, capture mem_rdata into the winner's rdata register; go to RESP.
//  RESP (1 cycle):
//   - Winner's ack=1 with rdata valid; return to IDLE.
//   - Loser's rdata register is not modified.
//  Outside ISSUE, mem_en and mem_wen are 0.
//  Latency, req seen in IDLE at cycle t:
//   - write: mem_wen and ack at t+1.
//   - read: mem_en at t+1, ack at t+2+RD_LAT.
//  Throughput and fairness:
//   - Back-to-back: a req still high the cycle after ack is a new request, arbitrated again in IDLE.
//   - Both ports continuously requesting alternate strictly; neither waits more than one transaction.
//  Requests arriving outside IDLE are not sampled; the requester keeps req high until its ack.
//  Acks are mutually exclusive and never asserted without a prior req.
// TESTING
//  1. p0 write addr 0x10 data 0xDEADBEEF
//     -> mem_wen=1, mem_addr=0x10 at t+1; p0_ack at t+1; p1_ack stays 0.
//  2. RD_LAT=1: p1 read 0x10 after test 1
//     -> mem_en at t+1, p1_ack at t+3, p1_rdata=0xDEADBEEF.
//  3. p0 and p1 both request reads from the first cycle after reset
//     -> p0 served first, then p1, then p0 again; acks alternate.
//  4. p0 req held high 4 transactions while p1 idle
//     -> 4 consecutive p0 grants; pointer never blocks a lone requester.
//  5. rst asserted in WAIT cycle of a p1 read
//     -> next cycle IDLE, no p1_ack, all outputs 0; a new p0 read completes normally.
//  6. RD_LAT=3: p0 read -> p0_ack exactly at t+5; mem_en high for one cycle only.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the cpu (port 0) and a
// loader/debug master (port 1); one transaction in flight, fixed-latency read pipe.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic               win;
  logic               last;
  logic               is_wr;
  logic [CNT_W-1:0]   cnt;

  logic               grant;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // last==1 means port 1 was granted most recently, so port 0 wins a tie
  always_comb begin
    grant     = p1_req & (~p0_req | ~last);
    sel_we    = grant ? p1_we    : p0_we;
    sel_addr  = grant ? p1_addr  : p0_addr;
    sel_wdata = grant ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win       <= 1'b0;
      last      <= 1'b1;
      is_wr     <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            win       <= grant;
            last      <= grant;
            is_wr     <= sel_we;
            mem_en    <= 1'b1;
            mem_wen   <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            // writes complete in the issue cycle itself
            p0_ack    <= sel_we & ~grant;
            p1_ack    <= sel_we & grant;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          mem_wen <= 1'b0;
          p0_ack  <= 1'b0;
          p1_ack  <= 1'b0;
          if (is_wr) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (win) p1_rdata <= mem_rdata;
            else     p0_rdata <= mem_rdata;
            p0_ack <= ~win;
            p1_ack <= win;
            state  <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with RD_LAT=1 on a small RAM model,
// one with RD_LAT=3 on an address-derived read pipe.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;

  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p1_ack, mem_en, mem_wen;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        x_p0_req = 0, x_p0_we = 0, x_p1_req = 0, x_p1_we = 0;
  logic [31:0] x_p0_addr = 0, x_p0_wdata = 0, x_p1_addr = 0, x_p1_wdata = 0;
  logic        x_p0_ack, x_p1_ack, x_mem_en, x_mem_wen;
  logic [31:0] x_p0_rdata, x_p1_rdata, x_mem_addr, x_mem_wdata, x_mem_rdata;

  logic [31:0] ram [0:255];
  logic [31:0] s1 = 0, s2 = 0, s3 = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .p0_req(x_p0_req), .p0_we(x_p0_we), .p0_addr(x_p0_addr), .p0_wdata(x_p0_wdata),
    .p0_ack(x_p0_ack), .p0_rdata(x_p0_rdata),
    .p1_req(x_p1_req), .p1_we(x_p1_we), .p1_addr(x_p1_addr), .p1_wdata(x_p1_wdata),
    .p1_ack(x_p1_ack), .p1_rdata(x_p1_rdata),
    .mem_en(x_mem_en), .mem_wen(x_mem_wen), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
    .mem_rdata(x_mem_rdata)
  );

  // single-cycle RAM behind the RD_LAT=1 instance
  logic [31:0] rd1 = 0;
  always @(posedge clk) begin
    if (mem_en && mem_wen) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_wen) rd1 <= ram[mem_addr[7:0]];
  end
  assign mem_rdata = rd1;

  // three-stage pipe: data is nonzero only exactly RD_LAT=3 cycles after a read strobe
  always @(posedge clk) begin
    s1 <= (x_mem_en && !x_mem_wen) ? (x_mem_addr ^ 32'hC0DE_0000) : 32'h0;
    s2 <= s1;
    s3 <= s2;
  end
  assign x_mem_rdata = s3;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    checks++;
    if ({mem_en, mem_wen, p0_ack, p1_ack} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_en, mem_wen, p0_ack, p1_ack});
    end
    checks++;
    if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, p0_rdata, p1_rdata});
    end
    checks++;
    if ({x_mem_en, x_p0_ack, x_p1_ack} !== 3'b0) begin
      errors++; $display("FAIL reset_lat3: got %b expected 000", {x_mem_en, x_p0_ack, x_p1_ack});
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_write;
    p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wen, p0_ack, p1_ack} !== 4'b1110) begin
      errors++; $display("FAIL write_p0_strobe: got en/wen/a0/a1=%b expected 1110", {mem_en, mem_wen, p0_ack, p1_ack});
    end
    checks++;
    if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_p0_fields: got addr=%h data=%h expected 10 deadbeef", mem_addr, mem_wdata);
    end
    p0_req = 0; p0_we = 0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wen, p0_ack, p1_ack} !== 4'b0000) begin
      errors++; $display("FAIL write_p0_after: got %b expected 0000", {mem_en, mem_wen, p0_ack, p1_ack});
    end
    idle(1);
    p1_req = 1; p1_we = 1; p1_addr = 32'h50; p1_wdata = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wen, p0_ack, p1_ack} !== 4'b1101 || mem_addr !== 32'h50) begin
      errors++; $display("FAIL write_p1: got en/wen/a0/a1=%b addr=%h expected 1101 50", {mem_en, mem_wen, p0_ack, p1_ack}, mem_addr);
    end
    p1_req = 0; p1_we = 0;
    idle(2);
  endtask

  task automatic test_read_p1;
    p1_req = 1; p1_we = 0; p1_addr = 32'h10;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== (i == 1) || mem_wen !== 1'b0) begin
        errors++; $display("FAIL read_p1_en c%0d: got en=%b wen=%b expected en=%b wen=0", i, mem_en, mem_wen, (i == 1));
      end
      checks++;
      if (p1_ack !== (i == 3) || p0_ack !== 1'b0) begin
        errors++; $display("FAIL read_p1_ack c%0d: got a1=%b a0=%b expected a1=%b a0=0", i, p1_ack, p0_ack, (i == 3));
      end
    end
    checks++;
    if (p1_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_p1_data: got %h expected deadbeef", p1_rdata);
    end
    p1_req = 0;
    idle(2);
  endtask

  task automatic test_contention;
    int acks;
    int who [3];
    int tick [3];
    acks = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    p1_req = 1; p1_we = 0; p1_addr = 32'h20;
    for (int i = 1; i <= 40 && acks < 3; i++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) begin
        checks++; errors++; $display("FAIL contention_excl c%0d: both acks high", i);
      end else if (p0_ack || p1_ack) begin
        who[acks] = p1_ack ? 1 : 0;
        tick[acks] = i;
        checks++;
        if (p0_ack && p0_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL contention_p0_data: got %h expected deadbeef", p0_rdata);
        end
        if (p1_ack && p1_rdata !== 32'h12345678) begin
          errors++; $display("FAIL contention_p1_data: got %h expected 12345678", p1_rdata);
        end
        acks++;
        if (acks == 3) begin p0_req = 0; p1_req = 0; end
      end
    end
    checks++;
    if (acks !== 3) begin
      errors++; $display("FAIL contention_count: got %0d acks expected 3", acks);
      p0_req = 0; p1_req = 0;
    end else begin
      checks++;
      if (who[0] !== 0 || who[1] !== 1 || who[2] !== 0) begin
        errors++; $display("FAIL contention_order: got %0d%0d%0d expected 010", who[0], who[1], who[2]);
      end
      checks++;
      if (tick[0] !== 3 || tick[1] !== 7 || tick[2] !== 11) begin
        errors++; $display("FAIL contention_timing: got %0d,%0d,%0d expected 3,7,11", tick[0], tick[1], tick[2]);
      end
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    int acks;
    int bad;
    acks = 0; bad = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h30;
    for (int i = 1; i <= 30 && acks < 4; i++) begin
      @(negedge clk);
      if (p1_ack) bad++;
      if (p0_ack) begin
        checks++;
        if (i !== 3 + 4 * acks || p0_rdata !== 32'hCAFEF00D) begin
          errors++; $display("FAIL b2b_ack%0d: got cycle %0d data %h expected cycle %0d data cafef00d", acks, i, p0_rdata, 3 + 4 * acks);
        end
        acks++;
        if (acks == 4) p0_req = 0;
      end
    end
    checks++;
    if (acks !== 4 || bad !== 0) begin
      errors++; $display("FAIL b2b_count: got %0d p0 acks %0d p1 acks expected 4 and 0", acks, bad);
      p0_req = 0;
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    p1_req = 1; p1_we = 0; p1_addr = 32'h20;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL midrst_issue: got en=%b expected 1", mem_en);
    end
    @(negedge clk);
    rst = 1; p1_req = 0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wen, p0_ack, p1_ack} !== 4'b0 || {mem_addr, mem_wdata, p0_rdata, p1_rdata} !== 128'h0) begin
      errors++; $display("FAIL midrst_outputs: got ctl=%b data=%h expected all 0", {mem_en, mem_wen, p0_ack, p1_ack}, {mem_addr, mem_wdata, p0_rdata, p1_rdata});
    end
    rst = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h20;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (p1_ack) bad++;
    end
    checks++;
    if (p0_ack !== 1'b1 || p0_rdata !== 32'h12345678 || bad !== 0) begin
      errors++; $display("FAIL midrst_recover: got a0=%b data=%h p1acks=%0d expected 1 12345678 0", p0_ack, p0_rdata, bad);
    end
    p0_req = 0;
    idle(2);
  endtask

  task automatic test_lat3;
    int en_cnt;
    en_cnt = 0;
    x_p0_req = 1; x_p0_we = 0; x_p0_addr = 32'h40;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (x_mem_en) en_cnt++;
      checks++;
      if (x_p0_ack !== (i == 5) || x_p1_ack !== 1'b0) begin
        errors++; $display("FAIL lat3_ack c%0d: got a0=%b a1=%b expected a0=%b a1=0", i, x_p0_ack, x_p1_ack, (i == 5));
      end
      if (i == 5) begin
        checks++;
        if (x_p0_rdata !== 32'hC0DE0040) begin
          errors++; $display("FAIL lat3_data: got %h expected c0de0040", x_p0_rdata);
        end
        x_p0_req = 0;
      end
    end
    checks++;
    if (en_cnt !== 1) begin
      errors++; $display("FAIL lat3_en_pulse: got %0d cycles expected 1", en_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h20] = 32'h12345678;
    ram[8'h30] = 32'hCAFEF00D;
    test_reset;
    test_write;
    test_read_p1;
    test_contention;
    test_back_to_back;
    test_reset_mid;
    test_lat3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
